regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipelined RISC-V core.
- Replaces the fixed 2-read/1-write 32x32 regfile.
- Adds: configurable width, depth and read-port count; two write ports with priority; optional write-to-read bypass; hardwired zero register; per-register pending (scoreboard) bits for hazard detection; sequenced clear after reset.
- Sits between decode (reads, allocation) and writeback (two retire ports).

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
// Contents: default geometry, clear/run state enum, read-source select enum,
//           and the read-path priority function (zero > port-1 bypass > port-0 bypass > array).
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  typedef enum logic [1:0] {
    SEL_MEM,
    SEL_WD0,
    SEL_WD1,
    SEL_ZERO
  } rd_sel_t;

  // Port 1 is the younger retire port, so its data must win over port 0.
  function automatic rd_sel_t bypass_sel(input logic zero_hit, input logic byp_en,
                                         input logic hit1, input logic hit0);
    if (zero_hit)            return SEL_ZERO;
    else if (byp_en && hit1) return SEL_WD1;
    else if (byp_en && hit0) return SEL_WD0;
    else                     return SEL_MEM;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits for hazard detection
// Ports: clk_i, reset_i (sync, active-high), run_i (regfile ready; gates all updates),
//        we0_i/wa0_i, we1_i/wa1_i (retire ports, clear pending),
//        alloc_en_i/alloc_rd_i (issue, sets pending), rs_i (packed read addresses),
//        pend_rs_o (raw pending bit per read address, no bypass masking).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic              we0_i,
  input  logic [AW-1:0]     wa0_i,
  input  logic              we1_i,
  input  logic [AW-1:0]     wa1_i,
  input  logic              alloc_en_i,
  input  logic [AW-1:0]     alloc_rd_i,
  input  logic [NRD*AW-1:0] rs_i,
  output logic [NRD-1:0]    pend_rs_o
);

  logic [NREGS-1:0] pending_q, pending_d;

  // Clears are applied before the set: a same-cycle allocation belongs to a
  // newer producer and must keep the register pending.
  always_comb begin
    pending_d = pending_q;
    if (run_i) begin
      if (we0_i) pending_d[wa0_i] = 1'b0;
      if (we1_i) pending_d[wa1_i] = 1'b0;
      if (alloc_en_i && !(ZERO_REG && (alloc_rd_i == '0))) pending_d[alloc_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_pend
    assign pend_rs_o[g] = pending_q[rs_i[g*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port integer register file with scoreboard
// Ports: clk, reset (sync, active-high), rs/rv/busy_rs (NRD packed read ports, combinational),
//        we0/wa0/wd0 and we1/wa1/wd1 (write ports, port 1 has priority),
//        alloc_en/alloc_rd (mark register pending), ready (post-reset clear done).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] rv,
  output logic [NRD-1:0]      busy_rs,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_rd,
  output logic                ready
);

  rf_state_t         state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic              we0_run, we1_run, wr0_en, wr1_en;
  logic [NRD-1:0]    pend_rs;

  assign ready   = (state_q == RF_RUN);
  assign we0_run = we0 && ready;
  assign we1_run = we1 && ready;
  assign wr0_en  = we0_run && !(ZERO_REG && (wa0 == '0));
  assign wr1_en  = we1_run && !(ZERO_REG && (wa1 == '0));

  // Clear walks every entry once; the pointer wrap coincides with the exit.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      RF_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == {AW{1'b1}}) state_d = RF_RUN;
      end
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage has no reset; contents are defined by the clear walk instead.
  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == RF_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        if (wr0_en) mem_q[wa0] <= wd0;
        if (wr1_en) mem_q[wa1] <= wd1;
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i      (clk),
    .reset_i    (reset),
    .run_i      (ready),
    .we0_i      (we0),
    .wa0_i      (wa0),
    .we1_i      (we1),
    .wa1_i      (wa1),
    .alloc_en_i (alloc_en),
    .alloc_rd_i (alloc_rd),
    .rs_i       (rs),
    .pend_rs_o  (pend_rs)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic            hit0, hit1;
    rd_sel_t         sel;
    logic [XLEN-1:0] rd_data;

    assign rd_addr = rs[g*AW +: AW];
    assign hit0    = we0_run && (wa0 == rd_addr);
    assign hit1    = we1_run && (wa1 == rd_addr);
    assign sel     = bypass_sel(ZERO_REG && (rd_addr == '0), BYPASS, hit1, hit0);

    always_comb begin
      rd_data = mem_q[rd_addr];
      case (sel)
        SEL_ZERO: rd_data = '0;
        SEL_WD1:  rd_data = wd1;
        SEL_WD0:  rd_data = wd0;
        default:  rd_data = mem_q[rd_addr];
      endcase
    end

    assign rv[g*XLEN +: XLEN] = ready ? rd_data : '0;
    // A retiring write this cycle resolves the hazard only if its data is forwarded.
    assign busy_rs[g] = ready && pend_rs[g] && !(BYPASS && (hit0 || hit1));
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (bypass and no-bypass instances)
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rs;
  logic [63:0] rv, rv_nb;
  logic [1:0]  busy_rs, busy_nb;
  logic        we0, we1, alloc_en;
  logic [4:0]  wa0, wa1, alloc_rd;
  logic [31:0] wd0, wd1;
  logic        ready, ready_nb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rv(rv), .busy_rs(busy_rs),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .ready(ready)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .rs(rs), .rv(rv_nb), .busy_rs(busy_nb),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .ready(ready_nb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0;
    wa0 = '0; wa1 = '0; alloc_rd = '0; wd0 = '0; wd1 = '0;
  endtask

  initial begin
    reset = 1'b1;
    rs    = '0;
    idle();

    // Reset held three cycles
    tick(); tick(); tick();
    rs = {5'd9, 5'd5};
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_rv0", rv[31:0], 32'd0);
    chk("reset_busy", {30'd0, busy_rs}, 32'd0);
    reset = 1'b0;

    // Clear walk: gated writes/alloc to addr 3 in the last cycles must be ignored
    rs = {5'd3, 5'd3};
    for (int k = 1; k <= 32; k++) begin
      if (k >= 29) begin
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA_5555;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h1234_5678;
        alloc_en = 1'b1; alloc_rd = 5'd3;
      end
      #1;
      if (k == 1 || k == 32) begin
        chk($sformatf("clear_ready_k%0d", k), {31'd0, ready}, 32'd0);
        chk($sformatf("clear_rv_k%0d", k), rv[31:0], 32'd0);
        chk($sformatf("clear_busy_k%0d", k), {30'd0, busy_rs}, 32'd0);
      end
      tick();
    end
    idle();
    #1;
    chk("ready_after_32", {31'd0, ready}, 32'd1);
    chk("ready_nb_after_32", {31'd0, ready_nb}, 32'd1);
    chk("gated_busy", {30'd0, busy_rs}, 32'd0);

    // Every entry reads zero after the clear
    for (int a = 0; a < 32; a++) begin
      rs = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("clear_rd%0d", a), rv[31:0] | rv[63:32] | rv_nb[31:0] | rv_nb[63:32], 32'd0);
    end

    // Write then read, same cycle
    rs = {5'd0, 5'd5};
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    #1;
    chk("bypass_rv0", rv[31:0], 32'hDEAD_BEEF);
    chk("nobypass_rv0_same", rv_nb[31:0], 32'd0);
    tick();
    idle();
    #1;
    chk("stored_rv0", rv[31:0], 32'hDEAD_BEEF);
    chk("nobypass_rv0_next", rv_nb[31:0], 32'hDEAD_BEEF);

    // Write conflict on address 7
    rs = {5'd7, 5'd5};
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    #1;
    chk("conflict_bypass", rv[63:32], 32'h22);
    tick();
    idle();
    #1;
    chk("conflict_mem", rv[63:32], 32'h22);
    chk("conflict_mem_nb", rv_nb[63:32], 32'h22);

    // Write to the zero register
    rs = {5'd0, 5'd0};
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    #1;
    chk("zero_same", rv[31:0], 32'd0);
    tick();
    idle();
    #1;
    chk("zero_after", rv[31:0], 32'd0);
    chk("zero_after_nb", rv_nb[63:32], 32'd0);

    // Scoreboard: allocate 9
    rs = {5'd9, 5'd9};
    alloc_en = 1'b1; alloc_rd = 5'd9;
    #1;
    chk("alloc_same_cycle", {30'd0, busy_rs}, 32'd0);
    tick();
    idle();
    #1;
    chk("alloc_busy", {30'd0, busy_rs}, 32'd3);
    chk("alloc_busy_nb", {30'd0, busy_nb}, 32'd3);

    // Writeback to 9 on port 1
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99;
    #1;
    chk("wb_busy_bypass", {30'd0, busy_rs}, 32'd0);
    chk("wb_busy_nobypass", {30'd0, busy_nb}, 32'd3);
    tick();
    idle();
    #1;
    chk("wb_busy_after", {30'd0, busy_rs}, 32'd0);
    chk("wb_busy_after_nb", {30'd0, busy_nb}, 32'd0);
    chk("wb_rv", rv[31:0], 32'h99);

    // Alloc and write to 9 in the same cycle keeps it pending
    alloc_en = 1'b1; alloc_rd = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h55;
    tick();
    idle();
    #1;
    chk("alloc_wb_busy", {30'd0, busy_rs}, 32'd3);
    chk("alloc_wb_rv", rv[63:32], 32'h55);

    // Allocating zero register never marks it pending
    rs = {5'd9, 5'd0};
    alloc_en = 1'b1; alloc_rd = 5'd0;
    tick();
    idle();
    #1;
    chk("zero_never_pending", {30'd0, busy_rs}, 32'd2);

    // Reset mid-clear at clr_ptr = 20
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("midclear_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) tick();
    chk("restart_ready_31", {31'd0, ready}, 32'd0);
    tick();
    chk("restart_ready_32", {31'd0, ready}, 32'd1);
    rs = {5'd7, 5'd9};
    #1;
    chk("restart_busy", {30'd0, busy_rs}, 32'd0);
    chk("restart_rv9", rv[31:0], 32'd0);
    chk("restart_rv7", rv[63:32], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
